imem_port_arbiter: RTL and testbench



---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_port_arbiter_rr_arb2.sv | 47 ++++
 rtl/imem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-RAM port arbiter.
package imem_pkg;

    localparam int IMEM_DEPTH = 16;
    localparam int IMEM_IDX_W = 4;

    // Who issued the read whose data comes back this cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_VGA
    } owner_t;

    // Boot gating: fetch stays blocked until the loader says it is done.
    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } boot_state_t;

    // An access is bad if it is not word aligned or falls past the last word.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] limit;
        limit = 32'(depth * 4);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Requester A is fetch, B is the viewer.
// The pointer only moves when both request and the slot is not held by a
// higher-priority user, so an uncontended grant never disturbs fairness.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic hold,
    output logic gnt_a,
    output logic gnt_b
);

    // ptr_q = 0 favours A, 1 favours B
    logic ptr_q;
    logic ptr_d;

    // Pick a winner and compute the next pointer value
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        ptr_d = ptr_q;
        if (!hold) begin
            if (req_a && req_b) begin
                if (ptr_q) begin
                    gnt_b = 1'b1;
                end else begin
                    gnt_a = 1'b1;
                end
                ptr_d = ~ptr_q;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    // Pointer flop, starts out favouring A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port instruction RAM arbiter: loader writes have absolute priority,
// fetch and viewer reads share the remaining slot round-robin, and fetch is
// blocked while the boot FSM is in BOOT. Read data is steered back one cycle
// later only to the requester recorded in the owner register.
//
// Handshake: a requester raises req with a stable address and keeps both
// until gnt is seen in the same cycle; the access is taken in that cycle.
// Dropping req before gnt withdraws the request. Read data follows the grant
// by exactly one cycle on the matching rvalid/rdata pair; there is no
// back-pressure on the return path.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int DEPTH     = IMEM_DEPTH,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ld_req,
    input  logic [31:0]           ld_addr,
    input  logic [31:0]           ld_wdata,
    input  logic                  ld_done,
    output logic                  ld_gnt,

    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,

    input  logic                  vga_req,
    input  logic [31:0]           vga_addr,
    output logic                  vga_gnt,
    output logic                  vga_rvalid,
    output logic [31:0]           vga_rdata,

    output logic                  mem_we,
    output logic [IMEM_IDX_W-1:0] mem_idx,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,

    output logic                  addr_err,
    output logic                  booting
);

    localparam boot_state_t RESET_STATE = BOOT_LOAD ? ST_BOOT : ST_RUN;

    boot_state_t state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        rd_err_q, rd_err_d;

    logic        if_masked;
    logic        ld_bad, if_bad, vga_bad;

    assign ld_bad  = addr_bad(ld_addr, DEPTH);
    assign if_bad  = addr_bad(if_addr, DEPTH);
    assign vga_bad = addr_bad(vga_addr, DEPTH);

    // Fetch only competes once the program is loaded
    assign if_masked = if_req && (state_q == ST_RUN);

    rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_a (if_masked),
        .req_b (vga_req),
        .hold  (ld_req),
        .gnt_a (if_gnt),
        .gnt_b (vga_gnt)
    );

    assign ld_gnt = ld_req;

    // Drive the RAM port from whichever requester won this cycle
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        addr_err  = 1'b0;
        owner_d   = OWN_NONE;
        rd_err_d  = 1'b0;
        if (ld_gnt) begin
            // A bad loader address is acknowledged but never written
            mem_we    = !ld_bad;
            mem_idx   = ld_addr[5:2];
            mem_wdata = ld_wdata;
            addr_err  = ld_bad;
        end else if (if_gnt) begin
            mem_idx  = if_addr[5:2];
            addr_err = if_bad;
            owner_d  = OWN_IF;
            rd_err_d = if_bad;
        end else if (vga_gnt) begin
            mem_idx  = vga_addr[5:2];
            addr_err = vga_bad;
            owner_d  = OWN_VGA;
            rd_err_d = vga_bad;
        end
    end

    // Boot FSM next state: leave BOOT on the load-complete pulse
    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT && ld_done) begin
            state_d = ST_RUN;
        end
    end

    // State, read owner and read-error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RESET_STATE;
            owner_q  <= OWN_NONE;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Return path: data reaches only the owner, zeroed after a bad address
    always_comb begin
        if_rvalid  = (owner_q == OWN_IF);
        vga_rvalid = (owner_q == OWN_VGA);
        if_rdata   = (if_rvalid && !rd_err_q) ? mem_rdata : 32'h0;
        vga_rdata  = (vga_rvalid && !rd_err_q) ? mem_rdata : 32'h0;
    end

    assign booting = (state_q == ST_BOOT);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 16-word RAM
// (registered read, read-before-write).
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_done;
  logic        ld_gnt;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [31:0] vga_rdata;
  logic        mem_we;
  logic [3:0]  mem_idx;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        addr_err;
  logic        booting;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [16];

  imem_port_arbiter #(.DEPTH(16), .BOOT_LOAD(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_done    (ld_done),
    .ld_gnt     (ld_gnt),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .mem_we     (mem_we),
    .mem_idx    (mem_idx),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .addr_err   (addr_err),
    .booting    (booting)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read of the old contents, write at the same edge
  always @(posedge clk) begin
    if (mem_we) ram[mem_idx] <= mem_wdata;
    mem_rdata <= ram[mem_idx];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge, then let inputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_req = 0; ld_done = 0; if_req = 0; vga_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h1111_0000 + 32'(i);
    mem_rdata = 32'h0;
    rst = 1; idle();
    ld_addr = 0; ld_wdata = 0; if_addr = 0; vga_addr = 0;

    // reset state
    tick(); tick();
    chk("rst_booting", 32'(booting), 32'd1);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_gnts", {29'd0, ld_gnt, if_gnt, vga_gnt}, 32'd0);
    rst = 0;

    // boot gating: fetch requested in BOOT must not be granted
    if_req = 1; if_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("boot_if_gnt", 32'(if_gnt), 32'd0);
      tick();
    end
    ld_req = 1; ld_addr = 32'h0; ld_wdata = 32'h00A00093;
    #1;
    chk("boot_ld_gnt", 32'(ld_gnt), 32'd1);
    chk("boot_mem_we", 32'(mem_we), 32'd1);
    chk("boot_mem_wdata", mem_wdata, 32'h00A00093);
    chk("boot_if_gnt_ld", 32'(if_gnt), 32'd0);
    tick();
    ld_req = 0; ld_done = 1;
    #1;
    chk("done_if_gnt", 32'(if_gnt), 32'd0);
    chk("done_booting", 32'(booting), 32'd1);
    tick();
    ld_done = 0;
    #1;
    chk("run_booting", 32'(booting), 32'd0);
    chk("run_if_gnt", 32'(if_gnt), 32'd1);
    chk("run_mem_idx", 32'(mem_idx), 32'd0);
    tick();
    idle();
    #1;
    chk("run_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("run_if_rdata", if_rdata, 32'h00A00093);
    chk("run_vga_rvalid", 32'(vga_rvalid), 32'd0);
    tick();

    // round-robin: IF, VGA, IF, VGA
    if_req = 1; if_addr = 32'h04; vga_req = 1; vga_addr = 32'h08;
    #1;
    chk("rr0_if_gnt", 32'(if_gnt), 32'd1);
    chk("rr0_vga_gnt", 32'(vga_gnt), 32'd0);
    chk("rr0_mem_idx", 32'(mem_idx), 32'd1);
    tick(); #1;
    chk("rr1_vga_gnt", 32'(vga_gnt), 32'd1);
    chk("rr1_if_gnt", 32'(if_gnt), 32'd0);
    chk("rr1_mem_idx", 32'(mem_idx), 32'd2);
    chk("rr1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("rr1_vga_rvalid", 32'(vga_rvalid), 32'd0);
    chk("rr1_if_rdata", if_rdata, 32'h1111_0001);
    tick(); #1;
    chk("rr2_if_gnt", 32'(if_gnt), 32'd1);
    chk("rr2_vga_rvalid", 32'(vga_rvalid), 32'd1);
    chk("rr2_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rr2_vga_rdata", vga_rdata, 32'h1111_0002);
    tick(); #1;
    chk("rr3_vga_gnt", 32'(vga_gnt), 32'd1);
    chk("rr3_if_rdata", if_rdata, 32'h1111_0001);
    chk("rr3_vga_rdata", vga_rdata, 32'h0);
    tick();

    // loader pre-empts both readers; pointer (now favouring fetch) stays put
    ld_req = 1; ld_addr = 32'h14; ld_wdata = 32'hCAFE_F00D;
    #1;
    chk("pre_vga_rdata", vga_rdata, 32'h1111_0002);
    chk("pre_gnts", {29'd0, ld_gnt, if_gnt, vga_gnt}, 32'b100);
    chk("pre_mem_we", 32'(mem_we), 32'd1);
    chk("pre_mem_idx", 32'(mem_idx), 32'd5);
    tick();
    ld_req = 0;
    #1;
    chk("pre_no_rvalid", {30'd0, if_rvalid, vga_rvalid}, 32'd0);
    chk("pre_ptr_if_gnt", 32'(if_gnt), 32'd1);
    chk("pre_ptr_vga_gnt", 32'(vga_gnt), 32'd0);
    tick();
    idle();
    #1;
    chk("pre_if_rdata", if_rdata, 32'h1111_0001);
    tick();

    // address errors
    if_req = 1; if_addr = 32'h40;
    #1;
    chk("err_if_gnt", 32'(if_gnt), 32'd1);
    chk("err_if_addr_err", 32'(addr_err), 32'd1);
    tick();
    if_req = 0; ld_req = 1; ld_addr = 32'h41; ld_wdata = 32'hFFFF_FFFF;
    #1;
    chk("err_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("err_if_rdata", if_rdata, 32'h0);
    chk("err_ld_gnt", 32'(ld_gnt), 32'd1);
    chk("err_ld_mem_we", 32'(mem_we), 32'd0);
    chk("err_ld_addr_err", 32'(addr_err), 32'd1);
    tick();
    idle();
    #1;
    chk("err_cleared", 32'(addr_err), 32'd0);
    tick();

    // read-before-write on index 3
    vga_req = 1; vga_addr = 32'h0C;
    #1;
    chk("rbw_vga_gnt", 32'(vga_gnt), 32'd1);
    tick();
    vga_req = 0; ld_req = 1; ld_addr = 32'h0C; ld_wdata = 32'h1234_5678;
    #1;
    chk("rbw_mem_we", 32'(mem_we), 32'd1);
    chk("rbw_old_word", vga_rdata, 32'h1111_0003);
    tick();
    ld_req = 0; if_req = 1; if_addr = 32'h0C;
    #1;
    chk("rbw_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    idle();
    #1;
    chk("rbw_new_word", if_rdata, 32'h1234_5678);
    tick();

    // asynchronous reset while a viewer read is returning
    vga_req = 1; vga_addr = 32'h08;
    #1;
    chk("rst_mid_vga_gnt", 32'(vga_gnt), 32'd1);
    tick();
    vga_req = 0;
    #1;
    chk("rst_mid_rvalid_before", 32'(vga_rvalid), 32'd1);
    rst = 1;
    #1;
    chk("rst_mid_rvalid_drop", 32'(vga_rvalid), 32'd0);
    chk("rst_mid_booting", 32'(booting), 32'd1);
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("rst_after_rvalid", {30'd0, if_rvalid, vga_rvalid}, 32'd0);
      tick();
    end
    chk("rst_after_booting", 32'(booting), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
